// File: rtl/csr_file_trap_unit.sv
// Machine-mode CSR file with ecall/mret trap sequencing and 64-bit cycle/instret counters.
// CSR reads are combinational and forward a same-cycle WB write. Traps produce a one-cycle redirect pulse.
`ifndef XLEN_32b
`define XLEN_32b 1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2
`endif

module csr_file_trap_unit #(
  parameter int          XLEN        = `XLEN_64b,
  parameter logic [63:0] RESET_MTVEC = 64'd0,
  localparam int         DW          = 1 << (XLEN + 4)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [11:0]   i_csr_raddr_d,
  output logic [DW-1:0] o_csr_rdata_d,
  input  logic          i_csr_reg_write_w,
  input  logic [11:0]   i_csr_waddr_w,
  input  logic [DW-1:0] i_csr_wdata_w,
  input  logic          i_instr_retire_w,
  input  logic          i_ecall_e,
  input  logic          i_mret_e,
  input  logic [DW-1:0] i_pc_e,
  output logic          o_redirect_valid,
  output logic [DW-1:0] o_redirect_pc,
  output logic          o_mie
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t          state_reg;
  logic            mie_reg, mpie_reg;
  logic [DW-1:0]   mtvec_reg, mscratch_reg, mepc_reg, mcause_reg;
  logic            redirect_valid_reg;
  logic [DW-1:0]   redirect_pc_reg;
  logic [1:0][63:0] cnt_val;

  logic            wr_mstatus, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause;
  logic            ecall_take, mret_take, trap_take, bypass_hit;
  logic [DW-1:0]   wdata_masked, mstatus_view, mtvec_fwd, mepc_fwd, rdata_mux;

  function automatic logic implemented(input logic [11:0] addr);
    case (addr)
      ADDR_MSTATUS, ADDR_MTVEC, ADDR_MSCRATCH, ADDR_MEPC, ADDR_MCAUSE,
      ADDR_MCYCLE, ADDR_MINSTRET:   implemented = 1'b1;
      ADDR_MCYCLEH, ADDR_MINSTRETH: implemented = (DW == 32);
      default:                      implemented = 1'b0;
    endcase
  endfunction

  assign wr_mstatus  = i_csr_reg_write_w && (i_csr_waddr_w == ADDR_MSTATUS);
  assign wr_mtvec    = i_csr_reg_write_w && (i_csr_waddr_w == ADDR_MTVEC);
  assign wr_mscratch = i_csr_reg_write_w && (i_csr_waddr_w == ADDR_MSCRATCH);
  assign wr_mepc     = i_csr_reg_write_w && (i_csr_waddr_w == ADDR_MEPC);
  assign wr_mcause   = i_csr_reg_write_w && (i_csr_waddr_w == ADDR_MCAUSE);

  // Flushed instructions during REDIRECT must not trap again; ecall beats mret.
  assign ecall_take = (state_reg == IDLE) && i_ecall_e;
  assign mret_take  = (state_reg == IDLE) && i_mret_e && !i_ecall_e;
  assign trap_take  = ecall_take || mret_take;

  always_comb begin
    mstatus_view        = '0;
    mstatus_view[12:11] = 2'b11;
    mstatus_view[7]     = mpie_reg;
    mstatus_view[3]     = mie_reg;
  end

  // Value a WB write would actually store, used for both commit and read forwarding.
  always_comb begin
    wdata_masked = i_csr_wdata_w;
    case (i_csr_waddr_w)
      ADDR_MSTATUS: begin
        wdata_masked        = '0;
        wdata_masked[12:11] = 2'b11;
        wdata_masked[7]     = i_csr_wdata_w[7];
        wdata_masked[3]     = i_csr_wdata_w[3];
      end
      ADDR_MTVEC, ADDR_MEPC: wdata_masked = {i_csr_wdata_w[DW-1:2], 2'b00};
      default: ;
    endcase
  end

  assign mtvec_fwd  = wr_mtvec ? wdata_masked : mtvec_reg;
  assign mepc_fwd   = wr_mepc  ? wdata_masked : mepc_reg;
  assign bypass_hit = i_csr_reg_write_w && (i_csr_waddr_w == i_csr_raddr_d) &&
                      implemented(i_csr_raddr_d);

  always_comb begin
    rdata_mux = '0;
    case (i_csr_raddr_d)
      ADDR_MSTATUS:   rdata_mux = mstatus_view;
      ADDR_MTVEC:     rdata_mux = mtvec_reg;
      ADDR_MSCRATCH:  rdata_mux = mscratch_reg;
      ADDR_MEPC:      rdata_mux = mepc_reg;
      ADDR_MCAUSE:    rdata_mux = mcause_reg;
      ADDR_MCYCLE:    rdata_mux = DW'(cnt_val[0]);
      ADDR_MINSTRET:  rdata_mux = DW'(cnt_val[1]);
      ADDR_MCYCLEH:   if (DW == 32) rdata_mux = DW'(cnt_val[0] >> 32);
      ADDR_MINSTRETH: if (DW == 32) rdata_mux = DW'(cnt_val[1] >> 32);
      default: ;
    endcase
    if (bypass_hit) rdata_mux = wdata_masked;
  end

  // Counter 0 is mcycle (always counts), counter 1 is minstret (counts retirements).
  for (genvar gi = 0; gi < 2; gi++) begin : g_counter
    logic [63:0] count_reg;
    logic        wr_lo, wr_hi, inc;

    assign wr_lo = i_csr_reg_write_w && (i_csr_waddr_w == (ADDR_MCYCLE | 12'(2 * gi)));
    assign wr_hi = i_csr_reg_write_w && (DW == 32) &&
                   (i_csr_waddr_w == (ADDR_MCYCLEH | 12'(2 * gi)));
    assign inc   = (gi == 0) ? 1'b1 : i_instr_retire_w;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        count_reg <= '0;
      end else if (wr_lo) begin
        if (DW == 32) count_reg <= {count_reg[63:32], i_csr_wdata_w[31:0]};
        else          count_reg <= 64'(i_csr_wdata_w);
      end else if (wr_hi) begin
        count_reg <= {i_csr_wdata_w[31:0], count_reg[31:0]};
      end else if (inc) begin
        count_reg <= count_reg + 64'd1;
      end
    end

    assign cnt_val[gi] = count_reg;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg          <= IDLE;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
      mie_reg            <= 1'b0;
      mpie_reg           <= 1'b0;
      mtvec_reg          <= {RESET_MTVEC[DW-1:2], 2'b00};
      mscratch_reg       <= '0;
      mepc_reg           <= '0;
      mcause_reg         <= '0;
    end else begin
      if (wr_mtvec)                begin mtvec_reg    <= wdata_masked; end
      if (wr_mscratch)             begin mscratch_reg <= wdata_masked; end
      if (wr_mepc && !ecall_take)  begin mepc_reg     <= wdata_masked; end
      if (wr_mcause && !ecall_take) begin mcause_reg  <= wdata_masked; end
      if (wr_mstatus && !trap_take) begin
        mie_reg  <= i_csr_wdata_w[3];
        mpie_reg <= i_csr_wdata_w[7];
      end

      case (state_reg)
        IDLE: begin
          redirect_valid_reg <= 1'b0;
          if (ecall_take) begin
            mepc_reg           <= {i_pc_e[DW-1:2], 2'b00};
            mcause_reg         <= DW'(11);
            mpie_reg           <= mie_reg;
            mie_reg            <= 1'b0;
            redirect_pc_reg    <= mtvec_fwd;
            redirect_valid_reg <= 1'b1;
            state_reg          <= REDIRECT;
          end else if (mret_take) begin
            mie_reg            <= mpie_reg;
            mpie_reg           <= 1'b1;
            redirect_pc_reg    <= mepc_fwd;
            redirect_valid_reg <= 1'b1;
            state_reg          <= REDIRECT;
          end
        end
        REDIRECT: begin
          redirect_valid_reg <= 1'b0;
          state_reg          <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_csr_rdata_d    = rdata_mux;
  assign o_redirect_valid = redirect_valid_reg;
  assign o_redirect_pc    = redirect_pc_reg;
  assign o_mie            = mie_reg;

endmodule

// File: tb/tb_csr_file_trap_unit.sv
// Scoreboard bench for csr_file_trap_unit (64-bit): directed trap/counter scenarios, then random traffic,
// all checked against a per-cycle CSR model.
module tb_csr_file_trap_unit;

  localparam int DW = 64;
  localparam logic [63:0] RST_MTVEC = 64'h8000_0103;

  logic          clk;
  logic          rst;
  logic [11:0]   csr_raddr;
  logic [DW-1:0] csr_rdata;
  logic          csr_we;
  logic [11:0]   csr_waddr;
  logic [DW-1:0] csr_wdata;
  logic          retire;
  logic          ecall;
  logic          mret;
  logic [DW-1:0] pc;
  logic          redirect_valid;
  logic [DW-1:0] redirect_pc;
  logic          mie;

  csr_file_trap_unit #(.XLEN(2), .RESET_MTVEC(RST_MTVEC)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_csr_raddr_d     (csr_raddr),
    .o_csr_rdata_d     (csr_rdata),
    .i_csr_reg_write_w (csr_we),
    .i_csr_waddr_w     (csr_waddr),
    .i_csr_wdata_w     (csr_wdata),
    .i_instr_retire_w  (retire),
    .i_ecall_e         (ecall),
    .i_mret_e          (mret),
    .i_pc_e            (pc),
    .o_redirect_valid  (redirect_valid),
    .o_redirect_pc     (redirect_pc),
    .o_mie             (mie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        rvalid;
    logic [63:0] rpc;
    logic        mie;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared = 0;
  int   n_mismatched = 0;
  int   cyc = 0;

  // Architectural model state
  bit          m_known = 0;
  bit          m_mie, m_mpie, m_rvalid;
  logic [63:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mcycle, m_minstret, m_rpc;

  function automatic bit m_impl(input logic [11:0] a);
    return a == 12'h300 || a == 12'h305 || a == 12'h340 || a == 12'h341 ||
           a == 12'h342 || a == 12'hB00 || a == 12'hB02;
  endfunction

  function automatic logic [63:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 64'h1800 + (m_mpie ? 64'h80 : 64'h0) + (m_mie ? 64'h8 : 64'h0);
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00: return m_mcycle;
      12'hB02: return m_minstret;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [63:0] m_store(input logic [11:0] a, input logic [63:0] d);
    if (a == 12'h300) return 64'h1800 + (d & 64'h88);
    if (a == 12'h305 || a == 12'h341) return d & ~64'h3;
    return d;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] expv, input int c);
    n_compared++;
    if (act !== expv) begin
      n_mismatched++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      cmp("rdata", csr_rdata, e.rdata, e.cyc);
      cmp("redirect_valid", 64'(redirect_valid), 64'(e.rvalid), e.cyc);
      cmp("redirect_pc", redirect_pc, e.rpc, e.cyc);
      cmp("mie", 64'(mie), 64'(e.mie), e.cyc);
    end
  end

  // One clock: drive inputs, queue what the outputs must show this cycle, then advance the model.
  task automatic cycle(input bit r, input bit we, input logic [11:0] wa, input logic [63:0] wd,
                       input bit ret, input bit ec, input bit mr, input logic [63:0] p,
                       input logic [11:0] ra);
    exp_t e;
    bit te, tm, old_mie, old_mpie;
    logic [63:0] fwd_mtvec, fwd_mepc, st;
    @(posedge clk);
    #1;
    rst = r; csr_we = we; csr_waddr = wa; csr_wdata = wd; retire = ret;
    ecall = ec; mret = mr; pc = p; csr_raddr = ra;
    cyc++;
    if (m_known) begin
      e.rdata  = (we && wa == ra && m_impl(ra)) ? m_store(wa, wd) : m_read(ra);
      e.rvalid = m_rvalid;
      e.rpc    = m_rpc;
      e.mie    = m_mie;
      e.cyc    = cyc;
      exp_q.push_back(e);
    end
    if (r) begin
      m_known = 1; m_mie = 0; m_mpie = 0; m_rvalid = 0; m_rpc = 0;
      m_mtvec = RST_MTVEC & ~64'h3; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
      m_mcycle = 0; m_minstret = 0;
    end else begin
      te = !m_rvalid && ec;
      tm = !m_rvalid && mr && !ec;
      st = m_store(wa, wd);
      fwd_mtvec = (we && wa == 12'h305) ? st : m_mtvec;
      fwd_mepc  = (we && wa == 12'h341) ? st : m_mepc;
      old_mie = m_mie; old_mpie = m_mpie;
      if (we && wa == 12'h300 && !(te || tm)) begin m_mie = wd[3]; m_mpie = wd[7]; end
      if (we && wa == 12'h305) m_mtvec = st;
      if (we && wa == 12'h340) m_mscratch = st;
      if (we && wa == 12'h341 && !te) m_mepc = st;
      if (we && wa == 12'h342 && !te) m_mcause = st;
      m_mcycle   = (we && wa == 12'hB00) ? wd : m_mcycle + 1;
      m_minstret = (we && wa == 12'hB02) ? wd : m_minstret + (ret ? 64'd1 : 64'd0);
      if (te) begin
        m_mepc = p & ~64'h3; m_mcause = 11; m_mpie = old_mie; m_mie = 0;
        m_rpc = fwd_mtvec; m_rvalid = 1;
      end else if (tm) begin
        m_mie = old_mpie; m_mpie = 1; m_rpc = fwd_mepc; m_rvalid = 1;
      end else begin
        m_rvalid = 0;
      end
    end
  endtask

  task automatic rd(input logic [11:0] ra);
    cycle(0, 0, 12'h0, 64'h0, 0, 0, 0, 64'h0, ra);
  endtask

  task automatic wr(input logic [11:0] wa, input logic [63:0] wd, input logic [11:0] ra);
    cycle(0, 1, wa, wd, 0, 0, 0, 64'h0, ra);
  endtask

  logic [11:0] addrs [10];

  initial begin
    rst = 1; csr_we = 0; csr_waddr = 0; csr_wdata = 0; retire = 0;
    ecall = 0; mret = 0; pc = 0; csr_raddr = 0;
    addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h340; addrs[3] = 12'h341;
    addrs[4] = 12'h342; addrs[5] = 12'hB00; addrs[6] = 12'hB02; addrs[7] = 12'hB80;
    addrs[8] = 12'h7C0; addrs[9] = 12'hF14;

    cycle(1, 0, 0, 0, 0, 0, 0, 0, 12'h300);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 12'h300);
    rd(12'hB00); rd(12'hB00);
    rd(12'h300); rd(12'h305); rd(12'h340); rd(12'h341); rd(12'h342); rd(12'hB02);

    wr(12'h305, 64'h203, 12'h305);
    rd(12'h305); rd(12'h7C0);
    wr(12'h300, 64'h8, 12'h300);
    cycle(0, 0, 0, 0, 0, 1, 0, 64'h104, 12'h300);
    rd(12'h341); rd(12'h342); rd(12'h300);

    cycle(0, 0, 0, 0, 0, 0, 1, 64'h0, 12'h300);
    rd(12'h300); rd(12'h300);
    cycle(0, 0, 0, 0, 0, 1, 1, 64'h208, 12'h300);
    cycle(0, 0, 0, 0, 0, 1, 0, 64'h300, 12'h341);
    rd(12'h341); rd(12'h342);
    cycle(0, 0, 0, 0, 0, 0, 1, 64'h0, 12'h300);
    rd(12'h300);

    wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFE, 12'hB00);
    rd(12'hB00); rd(12'hB00);
    cycle(0, 0, 0, 0, 1, 0, 0, 0, 12'hB02);
    cycle(0, 0, 0, 0, 1, 0, 0, 0, 12'hB02);
    cycle(0, 0, 0, 0, 1, 0, 0, 0, 12'hB02);
    rd(12'hB02);
    cycle(0, 1, 12'hB02, 64'h55, 1, 0, 0, 0, 12'hB02);
    rd(12'hB02);

    cycle(0, 1, 12'h341, 64'h300, 0, 0, 1, 0, 12'h341);
    rd(12'h300); rd(12'h300);
    cycle(0, 1, 12'h305, 64'h44C, 0, 1, 0, 64'h10C, 12'h305);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 12'h341);
    rd(12'h300); rd(12'h305); rd(12'h341); rd(12'h342);

    for (int i = 0; i < 3000; i++) begin
      logic [11:0] wa;
      logic [63:0] wd;
      wa = addrs[$urandom_range(0, 9)];
      wd = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) wd = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, wa, wd,
            $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            {$urandom, $urandom}, addrs[$urandom_range(0, 9)]);
    end

    rd(12'h300);
    @(negedge clk);
    @(negedge clk);
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
